pcie_ss_axis_tx_pkt_arb: RTL



---
 rtl/pcie_ss_axis_tx_pkt_arb.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pcie_ss_axis_tx_pkt_arb.sv
// Packet-boundary round-robin arbiter merging NUM_PORTS AXI-S TLP streams onto one
// registered output stream; a granted port keeps the output until its tlast beat is taken.
module pcie_ss_axis_tx_pkt_arb #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 512,
   parameter int USER_W     = 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_PORTS-1:0]                in_tvalid,
   output logic [NUM_PORTS-1:0]                in_tready,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]     in_tdata,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   in_tkeep,
   input  logic [NUM_PORTS-1:0]                in_tlast,
   input  logic [NUM_PORTS*USER_W-1:0]         in_tuser_vendor,
   output logic                                out_tvalid,
   input  logic                                out_tready,
   output logic [DATA_WIDTH-1:0]               out_tdata,
   output logic [DATA_WIDTH/8-1:0]             out_tkeep,
   output logic                                out_tlast,
   output logic [USER_W-1:0]                   out_tuser_vendor,
   output logic [$clog2(NUM_PORTS)-1:0]        owner,
   output logic                                busy
);

   localparam int OWN_W  = $clog2(NUM_PORTS);
   localparam int KEEP_W = DATA_WIDTH / 8;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t                r_state;
   logic [OWN_W-1:0]      r_owner;
   logic [OWN_W-1:0]      r_last_owner;
   logic                  r_out_tvalid;
   logic [DATA_WIDTH-1:0] r_out_tdata;
   logic [KEEP_W-1:0]     r_out_tkeep;
   logic                  r_out_tlast;
   logic [USER_W-1:0]     r_out_tuser;

   logic                  w_busy;
   logic                  w_accept;
   logic                  w_beat;
   logic                  w_eop;
   logic [NUM_PORTS-1:0]  w_own_mask;
   logic [NUM_PORTS-1:0]  w_req;
   logic [OWN_W-1:0]      w_win;
   logic                  w_win_vld;

   assign w_busy     = (r_state == S_BUSY);
   assign w_accept   = !r_out_tvalid || out_tready;
   assign w_beat     = w_busy && w_accept && in_tvalid[r_owner];
   assign w_eop      = w_beat && in_tlast[r_owner];
   assign w_own_mask = {{(NUM_PORTS-1){1'b0}}, 1'b1} << r_owner;

   // The owner's valid during its tlast beat belongs to the packet being closed,
   // so it must not count as a fresh request when re-arbitrating.
   assign w_req = w_busy ? (in_tvalid & ~w_own_mask) : in_tvalid;

   always_comb begin
      w_win     = r_last_owner;
      w_win_vld = 1'b0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         if (!w_win_vld && w_req[(int'(r_last_owner) + k) % NUM_PORTS]) begin
            w_win     = OWN_W'((int'(r_last_owner) + k) % NUM_PORTS);
            w_win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      in_tready = '0;
      if (w_busy) in_tready[r_owner] = w_accept;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_owner      <= '0;
         r_last_owner <= OWN_W'(NUM_PORTS - 1);
         r_out_tvalid <= 1'b0;
      end else begin
         if (w_accept) r_out_tvalid <= w_beat;
         case (r_state)
            S_IDLE: begin
               if (w_win_vld) begin
                  r_state      <= S_BUSY;
                  r_owner      <= w_win;
                  r_last_owner <= w_win;
               end
            end
            S_BUSY: begin
               if (w_eop) begin
                  if (w_win_vld) begin
                     r_owner      <= w_win;
                     r_last_owner <= w_win;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Payload is qualified by out_tvalid, so it carries no reset.
   always_ff @(posedge clk) begin
      if (w_beat) begin
         r_out_tdata <= in_tdata[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];
         r_out_tkeep <= in_tkeep[int'(r_owner)*KEEP_W +: KEEP_W];
         r_out_tlast <= in_tlast[r_owner];
         r_out_tuser <= in_tuser_vendor[int'(r_owner)*USER_W +: USER_W];
      end
   end

   assign out_tvalid       = r_out_tvalid;
   assign out_tdata        = r_out_tdata;
   assign out_tkeep        = r_out_tkeep;
   assign out_tlast        = r_out_tlast;
   assign out_tuser_vendor = r_out_tuser;
   assign owner            = r_owner;
   assign busy             = w_busy;

endmodule
